// File: rtl/ftof_wb_stage.sv
// ftof_wb_stage: writeback/retire stage behind the float-to-float converter.
// Buffers converter results in a small FIFO with a valid/ready handshake,
// NaN-boxes narrow results to XLEN, presents the head entry to the FPU
// writeback port and accumulates sticky fflags for every retired entry.
//
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_flush             drop all buffered entries (pipeline kill)
//   i_in_valid/o_in_ready, i_in_result, i_in_flags, i_in_rd, i_in_nanbox
//                       converter-side push interface
//   o_wb_valid/i_wb_ready, o_wb_data, o_wb_rd, o_wb_flags
//                       writeback-side head entry
//   i_fflags_clr        clear the sticky flag accumulator
//   o_fflags            sticky OR of flags of all retired entries
module ftof_wb_stage #(
    parameter int XLEN  = 64,
    parameter int OUT_W = 32,
    parameter int DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [OUT_W-1:0] i_in_result,
    input  logic [4:0]       i_in_flags,
    input  logic [4:0]       i_in_rd,
    input  logic             i_in_nanbox,
    output logic             o_wb_valid,
    input  logic             i_wb_ready,
    output logic [XLEN-1:0]  o_wb_data,
    output logic [4:0]       o_wb_rd,
    output logic [4:0]       o_wb_flags,
    input  logic             i_fflags_clr,
    output logic [4:0]       o_fflags
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

    logic [XLEN-1:0] r_data  [DEPTH];
    logic [4:0]      r_rd    [DEPTH];
    logic [4:0]      r_flags [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic [4:0]      r_fflags;
    logic [XLEN-1:0] w_boxed;
    logic            w_push;
    logic            w_pop;

    // Handshake status depends on registered occupancy only, so there is no
    // combinational path from i_wb_ready to o_in_ready.
    assign o_in_ready = (r_count != L_FULL);
    assign o_wb_valid = (r_count != '0);
    assign w_push     = i_in_valid && o_in_ready;
    assign w_pop      = o_wb_valid && i_wb_ready;
    assign o_wb_data  = r_data[r_rd_ptr];
    assign o_wb_rd    = r_rd[r_rd_ptr];
    assign o_wb_flags = r_flags[r_rd_ptr];
    assign o_fflags   = r_fflags;

    // Boxing happens once at push; full-width results pass through untouched.
    if (OUT_W == XLEN) begin : g_full
        assign w_boxed = i_in_result;
    end else begin : g_box
        assign w_boxed = {{(XLEN-OUT_W){i_in_nanbox}}, i_in_result};
    end

    always_ff @(posedge i_clk) begin
        if (w_push && !i_reset && !i_flush) begin
            r_data[r_wr_ptr]  <= w_boxed;
            r_rd[r_wr_ptr]    <= i_in_rd;
            r_flags[r_wr_ptr] <= i_in_flags;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fflags <= '0;
        end else begin
            // A pop in the flush cycle still retires and contributes flags.
            r_fflags <= (i_fflags_clr ? 5'b0 : r_fflags) | (w_pop ? o_wb_flags : 5'b0);
            if (i_flush) begin
                r_count  <= '0;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                r_count  <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
                r_wr_ptr <= w_push ? r_wr_ptr + AW'(1) : r_wr_ptr;
                r_rd_ptr <= w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
            end
        end
    end
endmodule

// File: tb/tb_ftof_wb_stage.sv
// tb_ftof_wb_stage: directed and randomized checks of ftof_wb_stage against a queue model.
module tb_ftof_wb_stage;
    localparam int DEPTH = 2;

    typedef struct {
        logic [63:0] d;
        logic [4:0]  rd;
        logic [4:0]  f;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, in_nanbox;
    logic [31:0] in_result;
    logic [4:0]  in_flags, in_rd;
    logic        wb_valid, wb_ready;
    logic [63:0] wb_data;
    logic [4:0]  wb_rd, wb_flags;
    logic        fflags_clr;
    logic [4:0]  fflags;

    ent_t        q[$];
    logic [4:0]  m_ff = '0;
    bit          acc;
    int          n_chk = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    ftof_wb_stage #(.XLEN(64), .OUT_W(32), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_reset(reset), .i_flush(flush),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_result(in_result),
        .i_in_flags(in_flags), .i_in_rd(in_rd), .i_in_nanbox(in_nanbox),
        .o_wb_valid(wb_valid), .i_wb_ready(wb_ready), .o_wb_data(wb_data),
        .o_wb_rd(wb_rd), .o_wb_flags(wb_flags),
        .i_fflags_clr(fflags_clr), .o_fflags(fflags)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("wb_valid", 64'(wb_valid), 64'(q.size() != 0));
        chk("in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
        chk("fflags", 64'(fflags), 64'(m_ff));
        if (q.size() != 0) begin
            chk("wb_data", wb_data, q[0].d);
            chk("wb_rd", 64'(wb_rd), 64'(q[0].rd));
            chk("wb_flags", 64'(wb_flags), 64'(q[0].f));
        end
    endtask

    // Drive one cycle of inputs, advance the model, then check after the edge.
    task automatic step(input bit rs, input bit fl, input bit iv, input logic [31:0] res,
                        input logic [4:0] fg, input logic [4:0] rd, input bit nb,
                        input bit wr, input bit clr);
        bit push, pop;
        logic [4:0] pf;
        reset = rs; flush = fl; in_valid = iv; in_result = res; in_flags = fg;
        in_rd = rd; in_nanbox = nb; wb_ready = wr; fflags_clr = clr;
        push = iv && (q.size() != DEPTH);
        pop  = (q.size() != 0) && wr;
        acc  = 1'b0;
        if (rs) begin
            q.delete();
            m_ff = '0;
        end else begin
            pf = pop ? q[0].f : 5'b0;
            if (pop) void'(q.pop_front());
            if (fl) q.delete();
            else if (push) begin
                q.push_back('{d: {{32{nb}}, res}, rd: rd, f: fg});
                acc = 1'b1;
            end
            m_ff = (clr ? 5'b0 : m_ff) | pf;
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input bit wr, input bit clr);
        step(0, 0, 0, 32'h0, 5'h0, 5'h0, 0, wr, clr);
    endtask

    initial begin
        bit          pv;
        logic [31:0] pres;
        logic [4:0]  pfg, prd;
        bit          pnb;
        bit          rs, fl;
        step(1, 0, 0, 32'h0, 5'h0, 5'h0, 0, 0, 0);
        step(1, 0, 0, 32'h0, 5'h0, 5'h0, 0, 0, 0);
        // 1: single boxed push then pop
        step(0, 0, 1, 32'h3F800000, 5'b00001, 5'd3, 1, 1, 0);
        chk("t1_data", wb_data, 64'hFFFFFFFF_3F800000);
        idle(1, 0);
        chk("t1_fflags", 64'(fflags), 64'h1);
        // 2: fill, hold off third, drain in order
        step(0, 0, 1, 32'h11111111, 5'h0, 5'd1, 0, 0, 0);
        step(0, 0, 1, 32'h22222222, 5'h0, 5'd2, 1, 0, 0);
        chk("t2_full", 64'(in_ready), 64'h0);
        step(0, 0, 1, 32'h33333333, 5'h0, 5'd3, 0, 0, 0);
        step(0, 0, 1, 32'h33333333, 5'h0, 5'd3, 0, 1, 0);
        chk("t2_ready_after_pop", 64'(in_ready), 64'h1);
        step(0, 0, 1, 32'h33333333, 5'h0, 5'd3, 0, 1, 0);
        chk("t2_third_head", 64'(wb_rd), 64'd3);
        idle(1, 0);
        // 3: streaming push/pop every cycle
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1, $urandom, 5'($urandom), 5'(i), 1'($urandom), 1, 0);
            chk("t3_rd", 64'(wb_rd), 64'(i));
        end
        idle(1, 0);
        // 4: pop with simultaneous clear keeps only popped flags
        idle(0, 1);
        step(0, 0, 1, 32'h1, 5'b10000, 5'd4, 0, 0, 0);
        idle(1, 0);
        chk("t4_pre", 64'(fflags), 64'h10);
        step(0, 0, 1, 32'h2, 5'b00100, 5'd5, 0, 0, 0);
        idle(1, 1);
        chk("t4_clr_pop", 64'(fflags), 64'h04);
        // 5: flush with pop and push in the same cycle
        idle(0, 1);
        step(0, 0, 1, 32'hA, 5'b00010, 5'd6, 0, 0, 0);
        step(0, 0, 1, 32'hB, 5'b01000, 5'd7, 0, 0, 0);
        step(0, 1, 1, 32'hC, 5'b10000, 5'd8, 0, 1, 0);
        chk("t5_valid", 64'(wb_valid), 64'h0);
        chk("t5_fflags", 64'(fflags), 64'h02);
        // 6: reset with full FIFO and nonzero fflags
        step(0, 0, 1, 32'hD, 5'b00001, 5'd9, 1, 0, 0);
        step(0, 0, 1, 32'hE, 5'b00001, 5'd10, 1, 0, 0);
        step(1, 0, 1, 32'hF, 5'b11111, 5'd11, 1, 1, 0);
        chk("t6_valid", 64'(wb_valid), 64'h0);
        chk("t6_ready", 64'(in_ready), 64'h1);
        chk("t6_fflags", 64'(fflags), 64'h0);
        // random traffic, payload held stable until accepted
        pv = 0; pres = '0; pfg = '0; prd = '0; pnb = 0;
        for (int i = 0; i < 600; i++) begin
            if (!pv && ($urandom_range(0, 3) != 0)) begin
                pv = 1; pres = $urandom; pfg = 5'($urandom); prd = 5'($urandom); pnb = 1'($urandom);
            end
            rs = ($urandom_range(0, 99) == 0);
            fl = ($urandom_range(0, 19) == 0);
            step(rs, fl, pv, pres, pfg, prd, pnb, ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 9) == 0));
            if (acc || rs || fl) pv = 0;
        end
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
